// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter
// Shares one single-port, fixed-latency memory between NUM_REQ OBI requesters.
// One request is granted per cycle. The winner drives the memory address phase,
// and a response (rvalid) returns to the owner RD_LATENCY cycles after the
// handshake.
//
// Optional feature: define OBI_ARB_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest index wins.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i/gnt_o         per-requester OBI request / grant (gnt is combinational)
//   rvalid_o            per-requester response valid, decoded from the pipeline
//   we_i/be_i/addr_i/wdata_i  packed per-requester address-phase signals
//   rdata_o             read data, broadcast, combinational from mem_rdata_i
//   mem_*               single memory port (handshake = mem_req_o && mem_gnt_i)
module obi_mem_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  be_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             mem_req_o,
    input  logic                             mem_gnt_i,
    output logic                             mem_we_o,
    output logic [DATA_WIDTH/8-1:0]          mem_be_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LAST     = RD_LATENCY - 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             active;
    logic             hs;

    // Response pipeline: one {valid, idx} entry per memory latency cycle
    logic [RD_LATENCY-1:0]            vld_d, vld_q;
    logic [RD_LATENCY-1:0][IDX_W-1:0] idx_d, idx_q;

    // Winner: first asserted request at or after ptr, searching upward with wrap
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Reset forces the address phase idle even if requesters still assert req
    assign active = (|req_i) & ~rst_i;
    assign hs     = active & mem_gnt_i;

    // Address phase mux; with no request the index-0 slice is passed through
    assign mem_req_o   = active;
    assign mem_we_o    = we_i[winner];
    assign mem_be_o    = be_i[32'(winner) * BE_WIDTH +: BE_WIDTH];
    assign mem_addr_o  = addr_i[32'(winner) * ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_wdata_o = wdata_i[32'(winner) * DATA_WIDTH +: DATA_WIDTH];

    // Grant goes only to the winner, and only while memory accepts
    always_comb begin
        gnt_o = '0;
        if (hs) begin
            gnt_o[winner] = 1'b1;
        end
    end

`ifdef OBI_ARB_RR_EN
    logic [IDX_W-1:0] ptr_d, ptr_q;

    // Priority pointer moves past the winner only on an accepted transfer
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = IDX_W'((32'(winner) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    // Fixed priority: search always starts at index 0
    assign ptr = '0;
`endif

    // Pipeline shifts every cycle and never stalls
    always_comb begin
        vld_d    = '0;
        idx_d    = '0;
        vld_d[0] = hs;
        idx_d[0] = winner;
        for (int unsigned s = 1; s < RD_LATENCY; s++) begin
            vld_d[s] = vld_q[s-1];
            idx_d[s] = idx_q[s-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    // Response valid decoded from the last stage; suppressed while in reset
    always_comb begin
        rvalid_o = '0;
        if (vld_q[LAST] && !rst_i) begin
            rvalid_o[idx_q[LAST]] = 1'b1;
        end
    end

    assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed testbench for obi_mem_arbiter. Three instances (RD_LATENCY 1, 2, 3)
// share the same stimulus; each scenario checks the instance it targets.
// Expected values follow OBI_ARB_RR_EN (round-robin) when defined.
module tb_obi_mem_arbiter;

`ifdef OBI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        mem_gnt;
    logic [31:0] mem_rdata;

    logic [1:0]  gnt1, gnt2, gnt3;
    logic [1:0]  rvalid1, rvalid2, rvalid3;
    logic [31:0] rdata1, rdata2, rdata3;
    logic        mem_req1, mem_req2, mem_req3;
    logic        mem_we1, mem_we2, mem_we3;
    logic [3:0]  mem_be1, mem_be2, mem_be3;
    logic [31:0] mem_addr1, mem_addr2, mem_addr3;
    logic [31:0] mem_wdata1, mem_wdata2, mem_wdata3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    obi_mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .rvalid_o(rvalid1),
        .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata1),
        .mem_req_o(mem_req1), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we1), .mem_be_o(mem_be1),
        .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata)
    );

    obi_mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt2), .rvalid_o(rvalid2),
        .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata2),
        .mem_req_o(mem_req2), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we2), .mem_be_o(mem_be2),
        .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2), .mem_rdata_i(mem_rdata)
    );

    obi_mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt3), .rvalid_o(rvalid3),
        .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata3),
        .mem_req_o(mem_req3), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we3), .mem_be_o(mem_be3),
        .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata)
    );

    // Advance to just after the next rising edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles; returns in the first cycle with reset released
    task automatic do_reset;
        rst = 1'b1; req = '0; we = '0; mem_gnt = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 2'b11; mem_gnt = 1'b1;
        step;
        step;
        #1;
        n_tests++;
        if ({gnt1, gnt2, gnt3} !== 6'b0) begin
            $display("FAIL reset_gnt: got %b/%b/%b exp 00", gnt1, gnt2, gnt3); n_fail++;
        end
        n_tests++;
        if ({mem_req1, mem_req2, mem_req3} !== 3'b0) begin
            $display("FAIL reset_mem_req: got %b%b%b exp 000", mem_req1, mem_req2, mem_req3); n_fail++;
        end
        n_tests++;
        if ({rvalid1, rvalid2, rvalid3} !== 6'b0) begin
            $display("FAIL reset_rvalid: got %b/%b/%b exp 00", rvalid1, rvalid2, rvalid3); n_fail++;
        end
        rst = 1'b0; req = '0;
        step;
    endtask

    task automatic test_single_read;
        do_reset;
        req = 2'b01; addr[31:0] = 32'h0001_0004; mem_gnt = 1'b1;
        #1;
        n_tests++;
        if (gnt1 !== 2'b01 || mem_req1 !== 1'b1) begin
            $display("FAIL single_gnt: got gnt=%b mem_req=%b exp 01/1", gnt1, mem_req1); n_fail++;
        end
        n_tests++;
        if (mem_addr1 !== 32'h0001_0004 || mem_we1 !== 1'b0) begin
            $display("FAIL single_addr: got addr=%h we=%b exp 00010004/0", mem_addr1, mem_we1); n_fail++;
        end
        step;
        req = 2'b00; mem_rdata = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (rvalid1 !== 2'b01 || rdata1 !== 32'hDEAD_BEEF) begin
            $display("FAIL single_resp: got rvalid=%b rdata=%h exp 01/deadbeef", rvalid1, rdata1); n_fail++;
        end
        step;
        #1;
        n_tests++;
        if (rvalid1 !== 2'b00) begin
            $display("FAIL single_drain: got rvalid=%b exp 00", rvalid1); n_fail++;
        end
    endtask

    task automatic test_contention;
        logic [1:0] exp_g;
        logic [1:0] prev;
        do_reset;
        req = 2'b11; mem_gnt = 1'b1;
        prev = 2'b00;
        for (int c = 0; c < 4; c++) begin
            exp_g = (RR && (c % 2 == 1)) ? 2'b10 : 2'b01;
            #1;
            n_tests++;
            if (gnt1 !== exp_g) begin
                $display("FAIL contention_gnt c%0d: got %b exp %b", c, gnt1, exp_g); n_fail++;
            end
            n_tests++;
            if (rvalid1 !== prev) begin
                $display("FAIL contention_rvalid c%0d: got %b exp %b", c, rvalid1, prev); n_fail++;
            end
            prev = exp_g;
            step;
        end
        req = 2'b00;
        #1;
        n_tests++;
        if (rvalid1 !== prev) begin
            $display("FAIL contention_rvalid_last: got %b exp %b", rvalid1, prev); n_fail++;
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] exp_g;
        do_reset;
        req = 2'b01; mem_gnt = 1'b1;
        #1;
        n_tests++;
        if (gnt1 !== 2'b01) begin
            $display("FAIL bp_first_gnt: got %b exp 01", gnt1); n_fail++;
        end
        step;
        req = 2'b11; mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (gnt1 !== 2'b00 || mem_req1 !== 1'b1) begin
                $display("FAIL bp_stall k%0d: got gnt=%b mem_req=%b exp 00/1", k, gnt1, mem_req1); n_fail++;
            end
            n_tests++;
            if (rvalid1 !== ((k == 0) ? 2'b01 : 2'b00)) begin
                $display("FAIL bp_rvalid k%0d: got %b exp %b", k, rvalid1, (k == 0) ? 2'b01 : 2'b00); n_fail++;
            end
            step;
        end
        mem_gnt = 1'b1;
        exp_g = RR ? 2'b10 : 2'b01;
        #1;
        n_tests++;
        if (gnt1 !== exp_g) begin
            $display("FAIL bp_release_gnt: got %b exp %b", gnt1, exp_g); n_fail++;
        end
        step;
        req = 2'b00;
        #1;
        n_tests++;
        if (rvalid1 !== exp_g) begin
            $display("FAIL bp_release_rvalid: got %b exp %b", rvalid1, exp_g); n_fail++;
        end
    endtask

    task automatic test_latency_write;
        logic [1:0] exp_rv [0:3];
        do_reset;
        req = 2'b10; we = 2'b10; be = {4'b0011, 4'b1111};
        wdata = {32'h1234_5678, 32'hCAFE_0000};
        addr  = {32'h0000_0200, 32'h0000_0100};
        mem_gnt = 1'b1;
        #1;
        n_tests++;
        if (gnt3 !== 2'b10 || mem_we3 !== 1'b1) begin
            $display("FAIL lat_wr_gnt: got gnt=%b we=%b exp 10/1", gnt3, mem_we3); n_fail++;
        end
        n_tests++;
        if (mem_be3 !== 4'b0011 || mem_wdata3 !== 32'h1234_5678 || mem_addr3 !== 32'h0000_0200) begin
            $display("FAIL lat_wr_data: got be=%b wdata=%h addr=%h exp 0011/12345678/00000200",
                     mem_be3, mem_wdata3, mem_addr3); n_fail++;
        end
        step;
        req = 2'b01; we = 2'b00;
        #1;
        n_tests++;
        if (gnt3 !== 2'b01 || mem_we3 !== 1'b0 || mem_addr3 !== 32'h0000_0100) begin
            $display("FAIL lat_rd_gnt: got gnt=%b we=%b addr=%h exp 01/0/00000100", gnt3, mem_we3, mem_addr3); n_fail++;
        end
        step;
        req = 2'b00;
        exp_rv[0] = 2'b00; exp_rv[1] = 2'b10; exp_rv[2] = 2'b01; exp_rv[3] = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (rvalid3 !== exp_rv[k]) begin
                $display("FAIL lat_rvalid T+%0d: got %b exp %b", k + 2, rvalid3, exp_rv[k]); n_fail++;
            end
            step;
        end
    endtask

    task automatic test_reset_midflight;
        do_reset;
        req = 2'b01; mem_gnt = 1'b1;
        #1;
        n_tests++;
        if (gnt2 !== 2'b01) begin
            $display("FAIL mid_gnt: got %b exp 01", gnt2); n_fail++;
        end
        step;
        req = 2'b00; rst = 1'b1;
        #1;
        n_tests++;
        if (rvalid2 !== 2'b00 || gnt2 !== 2'b00) begin
            $display("FAIL mid_in_reset: got rvalid=%b gnt=%b exp 00/00", rvalid2, gnt2); n_fail++;
        end
        step;
        rst = 1'b0; req = 2'b11;
        #1;
        n_tests++;
        if (rvalid2 !== 2'b00) begin
            $display("FAIL mid_dropped: got rvalid=%b exp 00", rvalid2); n_fail++;
        end
        n_tests++;
        if (gnt2 !== 2'b01) begin
            $display("FAIL mid_regrant: got %b exp 01", gnt2); n_fail++;
        end
        step;
        req = 2'b00;
        #1;
        n_tests++;
        if (rvalid2 !== 2'b00) begin
            $display("FAIL mid_rvalid_t3: got %b exp 00", rvalid2); n_fail++;
        end
        step;
        #1;
        n_tests++;
        if (rvalid2 !== 2'b01) begin
            $display("FAIL mid_rvalid_t4: got %b exp 01", rvalid2); n_fail++;
        end
        step;
    endtask

    task automatic test_back_to_back;
        do_reset;
        mem_gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req = 2'b01;
            addr[31:0] = 32'h0000_1000 + 32'(4 * c);
            #1;
            n_tests++;
            if (gnt2 !== 2'b01 || mem_addr2 !== 32'h0000_1000 + 32'(4 * c)) begin
                $display("FAIL b2b_gnt c%0d: got gnt=%b addr=%h exp 01/%h", c, gnt2, mem_addr2,
                         32'h0000_1000 + 32'(4 * c)); n_fail++;
            end
            n_tests++;
            if (rvalid2 !== ((c == 2) ? 2'b01 : 2'b00)) begin
                $display("FAIL b2b_rvalid c%0d: got %b exp %b", c, rvalid2, (c == 2) ? 2'b01 : 2'b00); n_fail++;
            end
            step;
        end
        req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (rvalid2 !== ((k < 2) ? 2'b01 : 2'b00)) begin
                $display("FAIL b2b_drain k%0d: got %b exp %b", k, rvalid2, (k < 2) ? 2'b01 : 2'b00); n_fail++;
            end
            step;
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        mem_gnt = 1'b1; mem_rdata = '0;
        test_reset;
        test_single_read;
        test_contention;
        test_backpressure;
        test_latency_write;
        test_reset_midflight;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Shares one single-port, fixed-latency memory (boot ROM or SRAM macro) between up to NUM_REQ OBI requesters, such as the cv32e40p instruction and data ports. This allows a minimal FPGA build to run without the AXI crossbar and `axi2mem` bridges. The arbiter grants one request per cycle and drives the memory address phase from the winner. It returns a response to the owning requester exactly RD_LATENCY cycles after the handshake.

## Interface
- NUM_REQ, 2, number of OBI requesters (2..4)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
- RD_LATENCY, 1, memory cycles from request handshake to rdata valid (1..4)

- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  NUM_REQ  per-requester OBI req
- gnt_o  out  NUM_REQ  per-requester OBI gnt, one-hot or zero
- rvalid_o  out  NUM_REQ  per-requester OBI rvalid, one-hot or zero
- we_i  in  NUM_REQ  write enable, packed by requester index
- be_i  in  NUM_REQ*DATA_WIDTH/8  byte enables, packed
- addr_i  in  NUM_REQ*ADDR_WIDTH  byte addresses, packed
- wdata_i  in  NUM_REQ*DATA_WIDTH  write data, packed
- rdata_o  out  DATA_WIDTH  read data, broadcast to all requesters; qualified by rvalid_o
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory ready; a handshake occurs when mem_req_o && mem_gnt_i
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_addr_o  out  ADDR_WIDTH  memory byte address, passed through unmodified
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after the handshake

## Operation
- Arbitration is combinational, evaluated each cycle over req_i.
  - Winner = first asserted req_i at or after priority pointer `ptr`, searching upward with wrap (see Configuration).
- Address phase:
  - mem_req_o = |req_i.
  - mem_we/be/addr/wdata_o are muxed from the winner.
  - With no request, these outputs hold the index-0 slice; their value is don't-care and not checked.
- gnt_o[winner] = mem_gnt_i. All other gnt_o bits are 0.
  - A requester holds req and its address-phase signals until it is granted (OBI rule); the arbiter does not check this.
- Response tracking is a shift pipeline of RD_LATENCY stages, each holding {valid, idx[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {handshake, winner}. Each stage shifts every cycle and never stalls.
  - rvalid_o[idx] = last stage valid.
  - Writes also produce rvalid (OBI); rdata is don't-care for writes.
- rdata_o = mem_rdata_i, combinational pass-through.
- `ptr` (width $clog2(NUM_REQ)) updates only on a handshake: ptr ← (winner+1) mod NUM_REQ.
- Back-to-back requests: one handshake per cycle at most. Responses are returned in order with no gaps introduced by the arbiter.
- mem_gnt_i low: no gnt_o, ptr unchanged, stage 0 loads valid=0. Responses already in flight still drain.
- Reset (rst_i=1):
  - gnt_o=0, mem_req_o=0, rvalid_o=0.
  - ptr←0 and all pipeline stages cleared on the clock edge.
  - Responses in flight are dropped. Requesters are reset at the same time.

## Timing
- Request to gnt: 0 cycles, combinational from req_i and mem_gnt_i. There is no register on this path.
- Handshake in cycle T gives rvalid_o in cycle T+RD_LATENCY.
- Maximum throughput: one transaction per cycle.
- Reset values: gnt_o=0, rvalid_o=0, mem_req_o=0, ptr=0, pipeline valid=0. In the first cycle after rst_i drops, a request may be granted.
- Every output is a function of current inputs and registered state. There is no combinational path from mem_rdata_i to any control output.

## Configuration
- OBI_ARB_RR_EN defined: round-robin arbitration. ptr advances past each winner as described in Operation.
- OBI_ARB_RR_EN undefined: fixed priority. ptr is tied to 0, so the lowest requester index always wins.
  - A requester can be starved by lower-index requesters. Use only when index 0 is the data port and the instruction fetch tolerates stalls.

## Test plan
- Single read: req_i=01, addr=0x0001_0004, mem_gnt_i=1, RD_LATENCY=1, mem returns 0xDEADBEEF.
  - gnt_o=01 in T; rvalid_o=01 and rdata_o=0xDEADBEEF in T+1.
- Contention, round-robin (OBI_ARB_RR_EN defined): req_i=11 held for 4 cycles.
  - gnt_o sequence 01,10,01,10; rvalid_o sequence delayed by one cycle and identical.
- Contention, fixed priority (OBI_ARB_RR_EN undefined): req_i=11 for 3 cycles.
  - gnt_o=01 every cycle; gnt_o[1] never asserts.
- Memory backpressure: req_i=10, mem_gnt_i=0 for 3 cycles, then 1.
  - gnt_o=00 for 3 cycles, then 10; ptr unchanged while stalled; rvalid_o=10 one cycle after the grant.
- Latency/write: RD_LATENCY=3; write from requester 1 (be=0011, wdata=0x1234_5678) in T, read from requester 0 in T+1.
  - mem_we_o=1 in T; rvalid_o=10 in T+3; rvalid_o=01 in T+4.
- Reset mid-flight: RD_LATENCY=2; grant in T, rst_i=1 in T+1.
  - rvalid_o stays 0 in T+2; ptr=0 afterward; a new request is granted in the first cycle after rst_i drops.
